// File: rtl/boot_loader.sv
// Framed byte-stream loader for instruction/data memories; holds the CPU in
// reset until a RUN command arrives.
module boot_loader #(
  parameter int unsigned INSTR_MEM_SIZE = 1024,
  parameter int unsigned DATA_MEM_SIZE  = 1024,
  parameter int unsigned ADDR_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              im_we,
  output logic              dm_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ADDR_LO = 3'd1;
  localparam logic [2:0] S_ADDR_HI = 3'd2;
  localparam logic [2:0] S_LEN_LO  = 3'd3;
  localparam logic [2:0] S_LEN_HI  = 3'd4;
  localparam logic [2:0] S_DATA    = 3'd5;
  localparam logic [2:0] S_CSUM    = 3'd6;
  localparam logic [2:0] S_RUN     = 3'd7;

  localparam logic [7:0] CMD_IM   = 8'hA5;
  localparam logic [7:0] CMD_DM   = 8'h5A;
  localparam logic [7:0] CMD_RUN  = 8'h3C;
  localparam logic [7:0] CMD_STOP = 8'hC3;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [7:0]        csum_q, csum_d;
  logic              dm_sel_q, dm_sel_d;
  logic              im_we_d, dm_we_d, busy_d, cpu_rst_n_d, err_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [7:0]        mem_wdata_d;
  logic              accept;
  logic              in_bounds;

  assign rx_ready = ~rst;
  assign accept   = rx_valid & ~rst;

  // State and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      len_lo_q  <= '0;
      csum_q    <= '0;
      dm_sel_q  <= 1'b0;
      im_we     <= 1'b0;
      dm_we     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rst_n <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      len_lo_q  <= len_lo_d;
      csum_q    <= csum_d;
      dm_sel_q  <= dm_sel_d;
      im_we     <= im_we_d;
      dm_we     <= dm_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      cpu_rst_n <= cpu_rst_n_d;
      busy      <= busy_d;
      err       <= err_d;
    end
  end

  // Frame parser: next state, datapath updates and next output values
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    len_lo_d    = len_lo_q;
    csum_d      = csum_q;
    dm_sel_d    = dm_sel_q;
    err_d       = err;
    im_we_d     = 1'b0;
    dm_we_d     = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    in_bounds   = dm_sel_q ? (32'(addr_q) < DATA_MEM_SIZE)
                           : (32'(addr_q) < INSTR_MEM_SIZE);

    if (accept) begin
      case (state_q)
        S_IDLE: begin
          case (rx_data)
            CMD_IM: begin
              state_d  = S_ADDR_LO;
              dm_sel_d = 1'b0;
              csum_d   = 8'h00;
            end
            CMD_DM: begin
              state_d  = S_ADDR_LO;
              dm_sel_d = 1'b1;
              csum_d   = 8'h00;
            end
            CMD_RUN: begin
              state_d = S_RUN;
              err_d   = 1'b0;
            end
            default: err_d = 1'b1;
          endcase
        end
        S_ADDR_LO: begin
          addr_d  = ADDR_W'(rx_data);
          csum_d  = csum_q + rx_data;
          state_d = S_ADDR_HI;
        end
        S_ADDR_HI: begin
          addr_d  = ADDR_W'({rx_data, addr_q[7:0]});
          csum_d  = csum_q + rx_data;
          state_d = S_LEN_LO;
        end
        S_LEN_LO: begin
          len_lo_d = rx_data;
          csum_d   = csum_q + rx_data;
          state_d  = S_LEN_HI;
        end
        S_LEN_HI: begin
          cnt_d   = ADDR_W'({rx_data, len_lo_q});
          csum_d  = csum_q + rx_data;
          state_d = ({rx_data, len_lo_q} == 16'd0) ? S_CSUM : S_DATA;
        end
        S_DATA: begin
          // Out-of-range bytes are consumed and flagged but never strobed
          if (in_bounds) begin
            im_we_d     = ~dm_sel_q;
            dm_we_d     = dm_sel_q;
            mem_addr_d  = addr_q;
            mem_wdata_d = rx_data;
          end else begin
            err_d = 1'b1;
          end
          addr_d = addr_q + ADDR_W'(1);
          cnt_d  = cnt_q - ADDR_W'(1);
          csum_d = csum_q + rx_data;
          if (cnt_q == ADDR_W'(1)) state_d = S_CSUM;
        end
        S_CSUM: begin
          if (rx_data != csum_q) err_d = 1'b1;
          state_d = S_IDLE;
        end
        S_RUN: begin
          if (rx_data == CMD_STOP) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d      = (state_d != S_IDLE) && (state_d != S_RUN);
    cpu_rst_n_d = (state_d == S_RUN);
  end

endmodule
